// File: rtl/rv_iopmp_pkg.sv
// Shared types and default constants for the IOPMP configuration register bus
// and the register-bus guard stage that sits in front of the IOPMP register file.
package rv_iopmp_pkg;

   localparam int unsigned REG_ADDR_W = 32;
   localparam int unsigned REG_DATA_W = 32;
   localparam int unsigned REG_STRB_W = REG_DATA_W / 8;

   localparam logic [REG_ADDR_W-1:0] GUARD_ADDR_LIMIT     = 32'h0000_4000;
   localparam int unsigned           GUARD_TIMEOUT_CYCLES = 256;
   localparam int unsigned           GUARD_CNT_WIDTH      = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      RESP = 2'd2
   } guard_state_e;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic                  write;
      logic [REG_DATA_W-1:0] wdata;
      logic [REG_STRB_W-1:0] wstrb;
      logic                  valid;
   } reg_req_t;

   typedef struct packed {
      logic [REG_DATA_W-1:0] rdata;
      logic                  error;
      logic                  ready;
   } reg_rsp_t;

   // Word-aligned and below the first illegal byte address.
   function automatic logic addr_is_legal(input logic [REG_ADDR_W-1:0] addr,
                                          input logic [REG_ADDR_W-1:0] limit);
      return (addr[1:0] == 2'b00) && (addr < limit);
   endfunction

endpackage

// File: rtl/rv_iopmp_reg_guard_if.sv
// Register-bus link (request + response) between a reg-bus master and slave.
interface rv_iopmp_reg_guard_if;
   import rv_iopmp_pkg::*;

   reg_req_t req;
   reg_rsp_t rsp;

   modport master (output req, input  rsp);
   modport slave  (input  req, output rsp);

endinterface

// File: rtl/rv_iopmp_sat_counter.sv
// Saturating up-counter for IOPMP debug statistics; sticks at all-ones.
module rv_iopmp_sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/rv_iopmp_reg_guard.sv
// Register-bus guard: registers the request, rejects illegal addresses locally,
// bounds each downstream access with a timeout and counts error responses.
module rv_iopmp_reg_guard
   import rv_iopmp_pkg::*;
#(
   parameter int unsigned            ADDR_WIDTH     = REG_ADDR_W,
   parameter int unsigned            DATA_WIDTH     = REG_DATA_W,
   parameter logic [ADDR_WIDTH-1:0]  ADDR_LIMIT     = GUARD_ADDR_LIMIT,
   parameter int unsigned            TIMEOUT_CYCLES = GUARD_TIMEOUT_CYCLES,
   parameter int unsigned            CNT_WIDTH      = GUARD_CNT_WIDTH
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  reg_req_t             up_req_i,
   output reg_rsp_t             up_rsp_o,
   output reg_req_t             dn_req_o,
   input  reg_rsp_t             dn_rsp_i,
   output logic [CNT_WIDTH-1:0] err_cnt_o,
   output logic                 busy_o
);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_FWD  = FWD;
   localparam logic [1:0] ST_RESP = RESP;

   localparam int unsigned       TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]              state_d, state_q;
   logic [ADDR_WIDTH-1:0]   addr_d, addr_q;
   logic                    write_d, write_q;
   logic [DATA_WIDTH-1:0]   wdata_d, wdata_q;
   logic [DATA_WIDTH/8-1:0] wstrb_d, wstrb_q;
   logic [DATA_WIDTH-1:0]   rdata_d, rdata_q;
   logic                    err_d, err_q;
   logic [TMO_W-1:0]        tmo_d, tmo_q;
   logic                    err_inc;

   // A downstream ready on the final timeout cycle takes priority over the timeout.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      write_d = write_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      tmo_d   = tmo_q;

      case (state_q)
         ST_IDLE: begin
            if (up_req_i.valid) begin
               addr_d  = up_req_i.addr;
               write_d = up_req_i.write;
               wdata_d = up_req_i.wdata;
               wstrb_d = up_req_i.wstrb;
               if (!addr_is_legal(up_req_i.addr, ADDR_LIMIT)) begin
                  err_d   = 1'b1;
                  rdata_d = '0;
                  state_d = ST_RESP;
               end else begin
                  err_d   = 1'b0;
                  tmo_d   = '0;
                  state_d = ST_FWD;
               end
            end
         end

         ST_FWD: begin
            tmo_d = tmo_q + 1'b1;
            if (dn_rsp_i.ready) begin
               rdata_d = write_q ? '0 : dn_rsp_i.rdata;
               err_d   = dn_rsp_i.error;
               state_d = ST_RESP;
            end else if (tmo_q == TMO_LAST) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = ST_RESP;
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         tmo_q   <= tmo_d;
      end
   end

   // Both buses are fully zero outside the state that owns them.
   always_comb begin
      up_rsp_o = '0;
      dn_req_o = '0;
      if (state_q == ST_RESP) begin
         up_rsp_o.ready = 1'b1;
         up_rsp_o.rdata = rdata_q;
         up_rsp_o.error = err_q;
      end
      if (state_q == ST_FWD) begin
         dn_req_o.valid = 1'b1;
         dn_req_o.addr  = addr_q;
         dn_req_o.write = write_q;
         dn_req_o.wdata = wdata_q;
         dn_req_o.wstrb = wstrb_q;
      end
   end

   assign busy_o  = (state_q != ST_IDLE);
   assign err_inc = (state_q == ST_RESP) && err_q;

   rv_iopmp_sat_counter #(
      .WIDTH (CNT_WIDTH)
   ) u_err_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .inc_i   (err_inc),
      .count_o (err_cnt_o)
   );

endmodule

// File: tb/tb_rv_iopmp_reg_guard.sv
// Self-checking bench for rv_iopmp_reg_guard: vector table, scoreboard of
// expected up responses, and hand sequences for reset and counter saturation.
module tb_rv_iopmp_reg_guard;
   import rv_iopmp_pkg::*;

   localparam int unsigned TMO = 8;
   localparam int unsigned CW  = 2;
   localparam int          NVEC = 9;

   typedef struct {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      int          dnWait;
      logic [31:0] dnRdata;
      logic        dnErr;
      logic        scramble;
      logic [31:0] expRdata;
      logic        expErr;
      int          expLat;
      int          expDn;
   } vec_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rv_iopmp_reg_guard_if upIf ();
   rv_iopmp_reg_guard_if dnIf ();

   logic [CW-1:0] errCnt;
   logic          busy;

   rv_iopmp_reg_guard #(
      .TIMEOUT_CYCLES (TMO),
      .CNT_WIDTH      (CW)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .up_req_i  (upIf.req),
      .up_rsp_o  (upIf.rsp),
      .dn_req_o  (dnIf.req),
      .dn_rsp_i  (dnIf.rsp),
      .err_cnt_o (errCnt),
      .busy_o    (busy)
   );

   int checkCount = 0;
   int passCount  = 0;

   exp_t sbQ[$];
   vec_t vecs[NVEC];

   int          dnWait = 0;
   logic [31:0] dnRdata = '0;
   logic        dnErr = 1'b0;
   int          dnCnt;

   logic [31:0] curAddr, curWdata;
   logic        curWrite;
   logic [3:0]  curWstrb;
   int          dnValidCycles = 0;
   int          payloadBad = 0;
   int          outsideBad = 0;
   int          idleRspBad = 0;
   logic [CW-1:0] expCnt = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Register-file model: ready (combinational) after dnWait stalled cycles; -1 never answers.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) dnCnt <= 0;
      else if (dnIf.req.valid && !dnIf.rsp.ready) dnCnt <= dnCnt + 1;
      else dnCnt <= 0;
   end

   always_comb begin
      dnIf.rsp = '0;
      if (dnIf.req.valid && dnWait >= 0 && dnCnt == dnWait) begin
         dnIf.rsp.ready = 1'b1;
         dnIf.rsp.rdata = dnRdata;
         dnIf.rsp.error = dnErr;
      end
   end

   // Monitor: scoreboard pop on up ready, payload stability and bus hygiene.
   always @(negedge clk) begin
      if (dnIf.req.valid) begin
         dnValidCycles++;
         if (dnIf.req.addr !== curAddr || dnIf.req.write !== curWrite ||
             dnIf.req.wdata !== curWdata || dnIf.req.wstrb !== curWstrb)
            payloadBad++;
         if (!busy) outsideBad++;
      end
      if (upIf.rsp.ready) begin
         if (sbQ.size() == 0) begin
            check("sb_unexpected_rsp", 64'(upIf.rsp.ready), 64'd0);
         end else begin
            exp_t e;
            e = sbQ.pop_front();
            check("sb_rdata", 64'(upIf.rsp.rdata), 64'(e.rdata));
            check("sb_error", 64'(upIf.rsp.error), 64'(e.err));
         end
      end else if (upIf.rsp.rdata != '0 || upIf.rsp.error) begin
         idleRspBad++;
      end
   end

   task automatic applyStimulus(input vec_t v, input string tag);
      int  lat;
      int  busyBad;
      bit  done;
      exp_t e;
      lat = 0;
      busyBad = 0;
      done = 1'b0;
      e.rdata = v.expRdata;
      e.err   = v.expErr;
      sbQ.push_back(e);
      dnWait  = v.dnWait;
      dnRdata = v.dnRdata;
      dnErr   = v.dnErr;
      curAddr  = v.addr;
      curWrite = v.write;
      curWdata = v.wdata;
      curWstrb = v.write ? 4'b1011 : 4'b0000;
      dnValidCycles = 0;
      payloadBad = 0;
      upIf.req.addr  = curAddr;
      upIf.req.write = curWrite;
      upIf.req.wdata = curWdata;
      upIf.req.wstrb = curWstrb;
      upIf.req.valid = 1'b1;
      for (int i = 0; i < 64 && !done; i++) begin
         @(negedge clk);
         if (lat >= 1 && !busy) busyBad++;
         if (upIf.rsp.ready) begin
            done = 1'b1;
         end else begin
            @(posedge clk);
            lat++;
            if (v.scramble && lat == 1) begin
               #1;
               upIf.req.addr  = 32'h22;
               upIf.req.write = ~curWrite;
               upIf.req.wdata = ~curWdata;
            end
         end
      end
      if (!done) check({tag, "_no_response"}, 64'd0, 64'd1);
      @(posedge clk);
      lat++;
      #1;
      upIf.req = '0;
      if (v.expErr && expCnt != '1) expCnt = expCnt + 1'b1;
      check({tag, "_latency"}, 64'(lat), 64'(v.expLat));
      check({tag, "_dn_valid_cycles"}, 64'(dnValidCycles), 64'(v.expDn));
      check({tag, "_dn_payload"}, 64'(payloadBad), 64'd0);
      check({tag, "_busy"}, 64'(busyBad), 64'd0);
      check({tag, "_err_cnt"}, 64'(errCnt), 64'(expCnt));
      check({tag, "_dn_valid_after"}, 64'(dnIf.req.valid), 64'd0);
   endtask

   function automatic vec_t mk(input logic [31:0] addr, input logic write, input logic [31:0] wdata,
                               input int w, input logic [31:0] rd, input logic de, input logic scr,
                               input logic [31:0] erd, input logic ee, input int lat, input int dn);
      vec_t v;
      v.addr = addr; v.write = write; v.wdata = wdata; v.dnWait = w; v.dnRdata = rd;
      v.dnErr = de; v.scramble = scr; v.expRdata = erd; v.expErr = ee; v.expLat = lat; v.expDn = dn;
      return v;
   endfunction

   initial begin
      upIf.req = '0;
      curAddr = '0; curWdata = '0; curWrite = 1'b0; curWstrb = '0;

      vecs[0] = mk(32'h10,   1'b1, 32'hDEADBEEF, 0,  32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,        1'b0, 3,  1);
      vecs[1] = mk(32'h24,   1'b0, 32'h0,        5,  32'h1234_5678, 1'b0, 1'b1, 32'h12345678, 1'b0, 8,  6);
      vecs[2] = mk(32'h22,   1'b0, 32'h0,        0,  32'h1,         1'b0, 1'b0, 32'h0,        1'b1, 2,  0);
      vecs[3] = mk(32'h4000, 1'b0, 32'h0,        0,  32'h1,         1'b0, 1'b0, 32'h0,        1'b1, 2,  0);
      vecs[4] = mk(32'h3FFC, 1'b0, 32'h0,        0,  32'hCAFEF00D,  1'b0, 1'b0, 32'hCAFEF00D, 1'b0, 3,  1);
      vecs[5] = mk(32'h100,  1'b0, 32'h0,        -1, 32'h77,        1'b0, 1'b0, 32'h0,        1'b1, 10, 8);
      vecs[6] = mk(32'h104,  1'b0, 32'h0,        7,  32'hA5,        1'b0, 1'b0, 32'hA5,       1'b0, 10, 8);
      vecs[7] = mk(32'h200,  1'b1, 32'h5555AAAA, 2,  32'h99,        1'b1, 1'b0, 32'h0,        1'b1, 5,  3);
      vecs[8] = mk(32'h201,  1'b1, 32'h1,        0,  32'h0,         1'b0, 1'b0, 32'h0,        1'b1, 2,  0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_up_rsp_zero", 64'(upIf.rsp == '0), 64'd1);
      check("rst_dn_req_zero", 64'(dnIf.req == '0), 64'd1);
      check("rst_err_cnt", 64'(errCnt), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i], $sformatf("v%0d", i));
      end

      // Reset while a downstream access is outstanding: no response, outputs drop at once.
      dnWait = -1;
      curAddr = 32'h8; curWrite = 1'b0; curWdata = '0; curWstrb = '0;
      upIf.req.addr = 32'h8; upIf.req.write = 1'b0; upIf.req.wdata = '0;
      upIf.req.wstrb = '0; upIf.req.valid = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #2;
      check("mid_rst_dn_valid_pre", 64'(dnIf.req.valid), 64'd1);
      check("mid_rst_busy_pre", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_dn_valid", 64'(dnIf.req.valid), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_up_ready", 64'(upIf.rsp.ready), 64'd0);
      upIf.req = '0;
      @(posedge clk); #3;
      rst_n = 1'b1;
      expCnt = '0;
      check("mid_rst_err_cnt", 64'(errCnt), 64'd0);
      @(posedge clk); #1;
      applyStimulus(mk(32'h0, 1'b0, 32'h0, 0, 32'h0BADF00D, 1'b0, 1'b0, 32'h0BADF00D, 1'b0, 3, 1), "post_rst");

      // Four errors into a 2-bit counter: must stick at 3.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(mk(32'h4004 + 32'(i * 4), 1'b0, 32'h0, 0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 2, 0),
                       $sformatf("sat%0d", i));
      end
      check("sat_err_cnt", 64'(errCnt), 64'd3);

      repeat (2) @(posedge clk);
      #1;
      check("sb_drained", 64'(sbQ.size()), 64'd0);
      check("dn_valid_outside_fwd", 64'(outsideBad), 64'd0);
      check("up_rsp_zero_when_idle", 64'(idleRspBad), 64'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
